// File: rtl/uart_rx_pkg.sv
// ----------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the UART receiver: frame sequencer state encoding,
// default data width, the legal oversampling ratios and the bit counter width.
// ----------------------------------------------------------------------------
package uart_rx_pkg;

    localparam int unsigned DATA_BITS   = 8;
    localparam int unsigned BIT_CNT_W   = 4;

    localparam int unsigned PRESCALE_8  = 8;
    localparam int unsigned PRESCALE_16 = 16;
    localparam int unsigned PRESCALE_32 = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_CHECK  = 3'd5
    } rx_state_e;

endpackage : uart_rx_pkg

// File: rtl/uart_rx_edge_bit_cnt.sv
// ----------------------------------------------------------------------------
// uart_rx_edge_bit_cnt
// Oversample edge counter and frame bit counter for the UART receiver.
//   clk, rst    : receiver clock, async active-high reset
//   cnt_en      : current state is one that advances through a bit
//   clr         : force both counters to zero on the next edge (wins over cnt_en)
//   prescale_q  : latched oversampling ratio for the frame in flight
//   edge_cnt    : oversample index within the current bit
//   bit_cnt     : frame bit index
//   bit_end     : last oversample of the current bit
// ----------------------------------------------------------------------------
module uart_rx_edge_bit_cnt
    import uart_rx_pkg::*;
#(
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cnt_en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] prescale_q,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  bit_end
);

    logic [PRESCALE_W-1:0] edge_q, edge_d;
    logic [BIT_CNT_W-1:0]  bit_q,  bit_d;

    assign bit_end = cnt_en && (edge_q == prescale_q - PRESCALE_W'(1));

    // Edge counter wraps at bit end and carries into the bit counter
    always_comb begin
        edge_d = edge_q;
        bit_d  = bit_q;
        if (clr) begin
            edge_d = '0;
            bit_d  = '0;
        end else if (cnt_en) begin
            if (bit_end) begin
                edge_d = '0;
                bit_d  = bit_q + BIT_CNT_W'(1);
            end else begin
                edge_d = edge_q + PRESCALE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_q <= '0;
            bit_q  <= '0;
        end else begin
            edge_q <= edge_d;
            bit_q  <= bit_d;
        end
    end

    assign edge_cnt = edge_q;
    assign bit_cnt  = bit_q;

endmodule : uart_rx_edge_bit_cnt

// File: rtl/uart_rx_fsm.sv
// ----------------------------------------------------------------------------
// uart_rx_fsm
// Frame sequencer for the UART receiver: start detect, start/data/parity/stop
// bit walk, checker enables and the frame-accepted strobe.
//   clk, rst     : oversampling clock, async active-high reset
//   RX_IN        : synchronized serial line, idle high
//   PAR_EN       : parity bit present (latched at start detect)
//   prescale     : oversampling ratio 8/16/32 (latched at start detect)
//   strt_glitch  : start checker verdict, valid by start bit end
//   par_err      : parity checker result
//   stp_err      : stop checker result
//   edge_cnt     : oversample index within bit
//   bit_cnt      : frame bit index
//   dat_samp_en  : data sampler enable
//   deser_en     : deserializer shift strobe, one per data bit
//   strt_chk_en  : start checker enable
//   par_chk_en   : parity checker enable
//   stp_chk_en   : stop checker enable
//   finish       : last oversample of the current bit
//   data_valid   : one-cycle frame accepted pulse
// Outputs are decoded from state and counter registers only; RX_IN reaches
// them solely through the state register.
// ----------------------------------------------------------------------------
module uart_rx_fsm #(
    parameter int unsigned DATA_BITS  = uart_rx_pkg::DATA_BITS,
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             RX_IN,
    input  logic                             PAR_EN,
    input  logic [PRESCALE_W-1:0]            prescale,
    input  logic                             strt_glitch,
    input  logic                             par_err,
    input  logic                             stp_err,
    output logic [PRESCALE_W-1:0]            edge_cnt,
    output logic [uart_rx_pkg::BIT_CNT_W-1:0] bit_cnt,
    output logic                             dat_samp_en,
    output logic                             deser_en,
    output logic                             strt_chk_en,
    output logic                             par_chk_en,
    output logic                             stp_chk_en,
    output logic                             finish,
    output logic                             data_valid
);

    import uart_rx_pkg::*;

    rx_state_e             state_q, state_d;
    logic [PRESCALE_W-1:0] prescale_q;
    logic                  par_en_q;
    logic                  cnt_en;
    logic                  cnt_clr;
    logic                  bit_end;
    logic                  start_det;

    assign cnt_en    = (state_q == ST_START) || (state_q == ST_DATA) ||
                       (state_q == ST_PARITY) || (state_q == ST_STOP);
    assign start_det = ((state_q == ST_IDLE) || (state_q == ST_CHECK)) && !RX_IN;

    // Counters restart whenever the frame leaves the bit-walking states
    assign cnt_clr   = (state_d == ST_IDLE) || (state_d == ST_CHECK);

    uart_rx_edge_bit_cnt #(
        .PRESCALE_W (PRESCALE_W)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .cnt_en     (cnt_en),
        .clr        (cnt_clr),
        .prescale_q (prescale_q),
        .edge_cnt   (edge_cnt),
        .bit_cnt    (bit_cnt),
        .bit_end    (bit_end)
    );

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (!RX_IN) state_d = ST_START;
            ST_START:  if (bit_end) state_d = strt_glitch ? ST_IDLE : ST_DATA;
            ST_DATA:   if (bit_end && (bit_cnt == BIT_CNT_W'(DATA_BITS)))
                           state_d = par_en_q ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_end) state_d = ST_STOP;
            ST_STOP:   if (bit_end) state_d = ST_CHECK;
            ST_CHECK:  state_d = RX_IN ? ST_IDLE : ST_START;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State register and frame configuration latched at start detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            prescale_q <= '0;
            par_en_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_det) begin
                prescale_q <= prescale;
                par_en_q   <= PAR_EN;
            end
        end
    end

    assign dat_samp_en = cnt_en;
    assign strt_chk_en = (state_q == ST_START);
    assign par_chk_en  = (state_q == ST_PARITY);
    assign stp_chk_en  = (state_q == ST_STOP);
    assign finish      = bit_end;
    assign deser_en    = (state_q == ST_DATA) && bit_end;
    // Parity error only counts when the frame actually carried a parity bit
    assign data_valid  = (state_q == ST_CHECK) && !(par_en_q && par_err) && !stp_err;

endmodule : uart_rx_fsm

// File: tb/tb_uart_rx_fsm.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_fsm
// Self-checking bench for the UART receive frame sequencer. Expected outputs
// come from a cycle-offset model of the frame: each cycle after the start
// detect maps to (bit index, oversample index) by division and remainder.
// ----------------------------------------------------------------------------
module tb_uart_rx_fsm;
    import uart_rx_pkg::*;

    localparam int PW = 6;
    localparam int DB = 8;

    logic          clk;
    logic          rst;
    logic          RX_IN;
    logic          PAR_EN;
    logic [PW-1:0] prescale;
    logic          strt_glitch;
    logic          par_err;
    logic          stp_err;
    logic [PW-1:0] edge_cnt;
    logic [3:0]    bit_cnt;
    logic          dat_samp_en, deser_en, strt_chk_en, par_chk_en;
    logic          stp_chk_en, finish, data_valid;

    typedef struct packed {
        logic [PW-1:0] edge_c;
        logic [3:0]    bit_c;
        logic          samp;
        logic          deser;
        logic          strt;
        logic          par;
        logic          stp;
        logic          fin;
        logic          dv;
    } outs_t;

    typedef struct {
        int          p;
        bit          pe;
        bit          gl;
        logic [7:0]  d;
        bit          perr;
        int          perr_from;
        bit          serr;
        int          exp_dv_k;
        int          exp_deser;
        string       name;
    } vec_t;

    outs_t act;
    int    passed = 0;
    int    total  = 0;
    int    cyc    = 0;

    uart_rx_fsm #(
        .DATA_BITS  (DB),
        .PRESCALE_W (PW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .RX_IN       (RX_IN),
        .PAR_EN      (PAR_EN),
        .prescale    (prescale),
        .strt_glitch (strt_glitch),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .edge_cnt    (edge_cnt),
        .bit_cnt     (bit_cnt),
        .dat_samp_en (dat_samp_en),
        .deser_en    (deser_en),
        .strt_chk_en (strt_chk_en),
        .par_chk_en  (par_chk_en),
        .stp_chk_en  (stp_chk_en),
        .finish      (finish),
        .data_valid  (data_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    assign act = {edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en,
                  par_chk_en, stp_chk_en, finish, data_valid};

    // Expected outputs k cycles after the start-detect cycle T0
    function automatic outs_t model(int k, int p, bit pe, bit gl, bit ok);
        outs_t o;
        int    nb, b, e;
        o  = '0;
        nb = gl ? 1 : DB + 2 + int'(pe);
        if (k >= 1 && k <= nb * p) begin
            b        = (k - 1) / p;
            e        = (k - 1) % p;
            o.edge_c = PW'(e);
            o.bit_c  = 4'(b);
            o.samp   = 1'b1;
            o.fin    = (e == p - 1);
            o.strt   = (b == 0);
            o.par    = pe && !gl && (b == DB + 1);
            o.stp    = (b > 0) && (b == nb - 1);
            o.deser  = (b >= 1) && (b <= DB) && (e == p - 1);
        end else if (!gl && k == nb * p + 1) begin
            o.dv = ok;
        end
        return o;
    endfunction

    // Serial line value for frame bit b: start, LSB-first data, even parity, stop
    function automatic logic bitval(int b, bit pe, bit gl, logic [7:0] d);
        if (b == 0) return 1'b0;
        if (gl) return 1'b1;
        if (b <= DB) return d[3'(b - 1)];
        if (pe && b == DB + 1) return ^d;
        return 1'b1;
    endfunction

    task automatic check(string name, outs_t exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h want %h", name, act, exp);
        else passed++;
    endtask

    task automatic check_int(string name, int got, int want);
        total++;
        if (got !== want) $display("FAIL %s: got %0d want %0d", name, got, want);
        else passed++;
    endtask

    // Runs one frame from the current negedge (state IDLE or CHECK) and checks
    // every cycle; returns at the negedge of the last checked cycle.
    task automatic run_frame(input string name, input int p, input bit pe, input bit gl,
                             input logic [7:0] d, input bit perr, input int perr_from,
                             input bit serr, input int abort_k,
                             output int dv_k, output int n_deser);
        int nb, last;
        bit ok;
        nb      = gl ? 1 : DB + 2 + int'(pe);
        last    = gl ? p + 1 : nb * p + 1;
        ok      = !(pe && perr && perr_from <= last) && !serr;
        dv_k    = 0;
        n_deser = 0;
        RX_IN       = 1'b0;
        prescale    = PW'(p);
        PAR_EN      = pe;
        strt_glitch = gl;
        stp_err     = serr;
        par_err     = perr && (perr_from <= 1);
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            check($sformatf("%s k=%0d", name, k), model(k, p, pe, gl, ok));
            if (deser_en) n_deser++;
            if (data_valid && dv_k == 0) dv_k = k;
            if (k == abort_k) return;
            RX_IN    = bitval(k / p, pe, gl, d);
            prescale = PW'($urandom);
            PAR_EN   = 1'($urandom);
            par_err  = perr && (k + 1 >= perr_from);
        end
        RX_IN       = 1'b1;
        par_err     = 1'b0;
        stp_err     = 1'b0;
        strt_glitch = 1'b0;
    endtask

    task automatic idle_cycles(input string name, input int n);
        RX_IN = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("%s idle%0d", name, i), '0);
            prescale = PW'($urandom);
            PAR_EN   = 1'($urandom);
        end
    endtask

    vec_t vecs[9];

    initial begin
        int dv_k, nd, c1, c2, p, nb;
        bit pe, gl, perr, serr, ok;
        int pf;
        logic [7:0] d;
        int plist[3];

        vecs[0] = '{PRESCALE_8,  1'b0, 1'b0, 8'hA5, 1'b0, 0,  1'b0, 81,  8, "p8_a5"};
        vecs[1] = '{PRESCALE_8,  1'b1, 1'b0, 8'h3C, 1'b0, 0,  1'b0, 89,  8, "p8_par_3c"};
        vecs[2] = '{PRESCALE_8,  1'b1, 1'b0, 8'h3C, 1'b1, 82, 1'b0, 0,   8, "p8_par_err"};
        vecs[3] = '{PRESCALE_16, 1'b0, 1'b1, 8'h00, 1'b0, 0,  1'b0, 0,   0, "p16_glitch"};
        vecs[4] = '{PRESCALE_16, 1'b0, 1'b0, 8'h5A, 1'b0, 0,  1'b1, 0,   8, "p16_stp_err"};
        vecs[5] = '{PRESCALE_32, 1'b1, 1'b0, 8'hFF, 1'b0, 0,  1'b0, 353, 8, "p32_par_ff"};
        vecs[6] = '{PRESCALE_8,  1'b0, 1'b0, 8'h00, 1'b1, 1,  1'b0, 81,  8, "p8_noparity_perr"};
        vecs[7] = '{PRESCALE_32, 1'b0, 1'b1, 8'h00, 1'b0, 0,  1'b0, 0,   0, "p32_glitch"};
        vecs[8] = '{PRESCALE_16, 1'b1, 1'b0, 8'h81, 1'b0, 0,  1'b0, 177, 8, "p16_par_81"};
        plist[0] = PRESCALE_8;
        plist[1] = PRESCALE_16;
        plist[2] = PRESCALE_32;

        rst = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; prescale = PW'(8);
        strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", '0);
        RX_IN = 1'b0;
        @(negedge clk);
        check("reset_ignores_rx", '0);
        RX_IN = 1'b1;
        rst   = 1'b0;
        idle_cycles("post_reset", 2);

        // Directed frames
        foreach (vecs[i]) begin
            run_frame(vecs[i].name, vecs[i].p, vecs[i].pe, vecs[i].gl, vecs[i].d,
                      vecs[i].perr, vecs[i].perr_from, vecs[i].serr, 0, dv_k, nd);
            check_int({vecs[i].name, " dv_cycle"}, dv_k, vecs[i].exp_dv_k);
            check_int({vecs[i].name, " deser_pulses"}, nd, vecs[i].exp_deser);
            idle_cycles(vecs[i].name, 1);
        end

        // Back-to-back frames: second start taken straight from CHECK
        run_frame("b2b_1", PRESCALE_16, 1'b0, 1'b0, 8'h96, 1'b0, 0, 1'b0, 0, dv_k, nd);
        c1 = cyc;
        check_int("b2b_1 dv_cycle", dv_k, 161);
        run_frame("b2b_2", PRESCALE_16, 1'b0, 1'b0, 8'h69, 1'b0, 0, 1'b0, 0, dv_k, nd);
        c2 = cyc;
        check_int("b2b_2 dv_cycle", dv_k, 161);
        check_int("b2b spacing", c2 - c1, 161);
        idle_cycles("b2b", 1);

        // Reset mid-DATA at edge_cnt 5, then a clean frame
        run_frame("rst_mid", PRESCALE_8, 1'b0, 1'b0, 8'hA5, 1'b0, 0, 1'b0, 14, dv_k, nd);
        check_int("rst_mid edge_cnt_before", int'(edge_cnt), 5);
        RX_IN = 1'b1;
        rst   = 1'b1;
        #1;
        check("rst_mid immediate", '0);
        @(negedge clk);
        check("rst_mid held", '0);
        rst = 1'b0;
        run_frame("after_rst", PRESCALE_8, 1'b0, 1'b0, 8'hC3, 1'b0, 0, 1'b0, 0, dv_k, nd);
        check_int("after_rst dv_cycle", dv_k, 81);
        check_int("after_rst deser_pulses", nd, 8);
        idle_cycles("after_rst", 1);

        // Randomized frames, randomly back-to-back or separated by idle gaps
        for (int r = 0; r < 24; r++) begin
            p    = plist[$urandom_range(0, 2)];
            pe   = 1'($urandom);
            gl   = ($urandom_range(0, 5) == 0);
            d    = 8'($urandom);
            perr = ($urandom_range(0, 3) == 0);
            serr = ($urandom_range(0, 4) == 0);
            pf   = int'($urandom_range(1, 400));
            nb   = DB + 2 + int'(pe);
            ok   = !gl && !(pe && perr && pf <= nb * p + 1) && !serr;
            run_frame($sformatf("rnd%0d", r), p, pe, gl, d, perr, pf, serr, 0, dv_k, nd);
            check_int($sformatf("rnd%0d dv_cycle", r), dv_k, ok ? nb * p + 1 : 0);
            check_int($sformatf("rnd%0d deser_pulses", r), nd, gl ? 0 : DB);
            if ($urandom_range(0, 1) == 1)
                idle_cycles($sformatf("rnd%0d", r), int'($urandom_range(1, 3)));
        end
        idle_cycles("final", 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_uart_rx_fsm

// File: doc/uart_rx_fsm.md
# uart_rx_fsm

Frame sequencer for the UART receiver. It detects a start condition on the oversampled line and walks the frame through start, data, optional parity and stop. It owns the oversampling edge counter and the frame bit counter, and drives the enables and strobes for the data sampler, deserializer, start/parity/stop checkers. It issues a one-cycle `data_valid` when a frame completes without error.

## Interface
Parameters:
- `DATA_BITS`, default 8: data bits per frame.
- `PRESCALE_W`, default 6: width of the prescale and edge counter.

Ports:
- `clk` in 1: receiver clock, oversampling rate.
- `rst` in 1: asynchronous, active-high reset.
- `RX_IN` in 1: serial line, already synchronized; idle high.
- `PAR_EN` in 1: parity bit present in the frame.
- `prescale` in PRESCALE_W: oversampling ratio; legal values 8, 16, 32.
- `strt_glitch` in 1: from the start checker; valid by the last edge of the start bit.
- `par_err` in 1: registered result from the parity checker.
- `stp_err` in 1: registered result from the stop checker.
- `edge_cnt` out PRESCALE_W: oversample index within the current bit.
- `bit_cnt` out 4: frame bit index.
- `dat_samp_en` out 1: enable for the data sampler.
- `deser_en` out 1: shift strobe for the deserializer.
- `strt_chk_en` out 1: start checker enable.
- `par_chk_en` out 1: parity checker enable.
- `stp_chk_en` out 1: stop checker enable.
- `finish` out 1: last oversample of the current bit.
- `data_valid` out 1: frame accepted; one-cycle pulse.

## Operation
- States: IDLE, START, DATA, PARITY, STOP, CHECK. The state encoding lives in the shared package.
- `prescale` and `PAR_EN` are latched when a start is detected in IDLE or CHECK. Changes to them mid-frame are ignored.
- Bit end: in any state except IDLE and CHECK, a bit ends when `edge_cnt == prescale_q-1`.
- `edge_cnt` behaviour:
  - Increments every cycle in START, DATA, PARITY and STOP.
  - Wraps to 0 at bit end.
  - Held at 0 in IDLE and CHECK.
- `bit_cnt` values:
  - START: 0.
  - DATA: 1..DATA_BITS.
  - PARITY: DATA_BITS+1.
  - STOP: DATA_BITS+1 without parity, DATA_BITS+2 with parity.
  - IDLE and CHECK: 0.
- Transitions:
  - IDLE → START when `RX_IN == 0`.
  - START at bit end → IDLE if `strt_glitch`, otherwise DATA.
  - DATA at bit end with `bit_cnt == DATA_BITS` → PARITY if `PAR_EN_q`, otherwise STOP.
  - PARITY at bit end → STOP.
  - STOP at bit end → CHECK.
  - CHECK → START if `RX_IN == 0` (back-to-back frame), otherwise IDLE.
- Outputs per state:
  - `dat_samp_en` = 1 in START, DATA, PARITY and STOP.
  - `strt_chk_en` = 1 in START.
  - `par_chk_en` = 1 for all of PARITY.
  - `stp_chk_en` = 1 in STOP.
  - `deser_en` = 1 on the bit-end cycle of each DATA bit, so exactly DATA_BITS pulses per frame.
  - `finish` = 1 on every bit-end cycle.
- `data_valid` = 1 in CHECK only, when `!(PAR_EN_q && par_err) && !stp_err`. An errored frame produces no pulse and no other side effect.
- All outputs are registered or decoded directly from state and counters. There is no combinational path from `RX_IN` to any output.

## Timing
- Reset: state = IDLE; `edge_cnt`, `bit_cnt` and every output = 0; latched config = 0. Reset takes effect immediately, including mid-frame. The first start detection is possible in the cycle after reset deasserts.
- Start latency:
  - Low sampled on `RX_IN` in IDLE at cycle T0.
  - START occupies T1..T(prescale) with `edge_cnt` 0..prescale-1.
- Frame length:
  - CHECK is cycle T0 + (DATA_BITS+2+PAR_EN)·prescale + 1.
  - `data_valid` is asserted in that cycle.
- Glitch abort: IDLE occurs on the cycle after START bit end, and no data strobes are issued.
- Checker handshakes:
  - `par_err` must settle by the second cycle after PARITY's last `finish`.
  - `stp_err` is sampled in CHECK, the cycle after STOP's `finish`.
- Back-to-back frames: `RX_IN` low in CHECK starts the next START directly, with `edge_cnt` = 0. No idle cycle is required.

## Structure
- Package `uart_rx_pkg` holds:
  - the state enum;
  - `DATA_BITS`;
  - the legal prescale constants 8, 16, 32;
  - the `bit_cnt` width.
- Sub-module `uart_rx_edge_bit_cnt` holds the edge and bit counters, with inputs `cnt_en`, `clr` and `prescale_q`. It outputs `edge_cnt`, `bit_cnt` and `bit_end`.
- The FSM holds next-state logic, the config latches and output decode.

## Test plan
- Prescale 8, PAR_EN=0, byte 0xA5, clean frame:
  - exactly 8 `deser_en` pulses, spaced 8 cycles apart;
  - `data_valid` pulses once, at T81.
- Prescale 8, PAR_EN=1, byte 0x3C, correct even parity:
  - `par_chk_en` is high for T73..T80;
  - `data_valid` pulses at T89.
- Same frame with `par_err=1` forced from T82 → no `data_valid`; FSM returns to IDLE at T90.
- `strt_glitch=1` at START bit end (prescale 16):
  - FSM returns to IDLE at T17;
  - zero `deser_en` pulses; `bit_cnt` = 0.
- Two back-to-back frames (prescale 16, `RX_IN` low in CHECK) → two `data_valid` pulses exactly 161 cycles apart.
- `rst` asserted mid-DATA with `edge_cnt` = 5:
  - all outputs and counters are 0 in the same cycle;
  - a new frame after reset completes normally.
